// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op and state
// encodings, default iteration count and a small two's-complement helper.
package muldiv_pkg;

    localparam int ITER_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: conditional add + right shift for multiply,
// restoring trial subtract + left shift for divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] opnd,
    output logic [31:0] nxt_hi,
    output logic [31:0] nxt_lo
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic        fits;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        shifted = {acc_hi, acc_lo[31]};
        fits    = (shifted >= {1'b0, opnd});
        nxt_hi  = 32'd0;
        nxt_lo  = 32'd0;
        if (is_div) begin
            // partial remainder always stays below the divisor, so 32 bits suffice
            nxt_hi = fits ? (shifted[31:0] - opnd) : shifted[31:0];
            nxt_lo = {acc_lo[30:0], fits};
        end else begin
            nxt_hi = sum[32:1];
            nxt_lo = {sum[0], acc_lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit with HI/LO result registers.
//   state  | meaning
//   S_IDLE | waiting for start; hi_we/lo_we honoured
//   S_CALC | ITER magnitude iterations through muldiv_step
//   S_FIX  | sign correction / divide-by-zero fixup, results land in hi/lo
//   S_DONE | done pulse cycle, returns to S_IDLE
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      acc_hi;
    logic [31:0]      acc_lo;
    logic [31:0]      opnd;
    logic             is_div_r;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_r;

    logic             in_div;
    logic             in_sx;
    logic             in_sy;
    logic [31:0]      mag_x;
    logic [31:0]      mag_y;
    logic [31:0]      step_hi;
    logic [31:0]      step_lo;
    logic [63:0]      prod_neg;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    always_comb begin
        in_div = (op == OP_DIVU) || (op == OP_DIV);
        in_sx  = ((op == OP_MULT) || (op == OP_DIV)) && x[31];
        in_sy  = ((op == OP_MULT) || (op == OP_DIV)) && y[31];
        mag_x  = cond_neg(x, in_sx);
        mag_y  = cond_neg(y, in_sy);
    end

    muldiv_step u_step (
        .is_div (is_div_r),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    always_comb begin
        prod_neg = ~{acc_hi, acc_lo} + 64'd1;
        res_hi   = acc_hi;
        res_lo   = acc_lo;
        if (!is_div_r) begin
            {res_hi, res_lo} = neg_q ? prod_neg : {acc_hi, acc_lo};
        end else begin
            // with a zero divisor the remainder path already reproduces x
            res_lo = dbz_r ? 32'hFFFF_FFFF : cond_neg(acc_lo, neg_q);
            res_hi = cond_neg(acc_hi, neg_r);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc_hi      <= 32'd0;
            acc_lo      <= 32'd0;
            opnd        <= 32'd0;
            is_div_r    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CALC;
                        busy     <= 1'b1;
                        cnt      <= CNT_LOAD;
                        is_div_r <= in_div;
                        neg_q    <= in_sx ^ in_sy;
                        neg_r    <= in_sx;
                        dbz_r    <= in_div && (y == 32'd0);
                        acc_hi   <= 32'd0;
                        acc_lo   <= in_div ? mag_x : mag_y;
                        opnd     <= in_div ? mag_y : mag_x;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    done        <= 1'b1;
                    div_by_zero <= dbz_r;
                    state       <= S_DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized
// operations against an arithmetic reference model.
module tb_muldiv_seq;

    localparam int ITER    = 32;
    localparam int EXP_LAT = ITER + 1;  // edges from the start edge to the edge opening the done cycle

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    muldiv_seq #(.ITER(ITER)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .x           (x),
        .y           (y),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // returns {div_by_zero, hi, lo}
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] r;
        logic        z;
        z  = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: r = {32'd0, a} * {32'd0, b};
            2'b01: r = sa * sb;
            2'b10: begin
                if (b == 32'd0) begin r = {a, 32'hFFFF_FFFF}; z = 1'b1; end
                else r = {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) begin r = {a, 32'hFFFF_FFFF}; z = 1'b1; end
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
        return {z, r};
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output logic rz,
                         output int lat, output bit proto_ok, output int done_cyc);
        logic [31:0] h0;
        logic [31:0] l0;
        @(negedge clk);
        op = o; x = a; y = b; start = 1'b1;
        h0 = hi; l0 = lo;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        proto_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1 || hi !== h0 || lo !== l0 || div_by_zero !== 1'b0) proto_ok = 1'b0;
            x  = $urandom;
            y  = $urandom;
            op = 2'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        rh = hi; rl = lo; rz = div_by_zero; done_cyc = cyc;
        if (busy !== 1'b1) proto_ok = 1'b0;
        @(posedge clk); #1;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) proto_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; x = 32'd0; y = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero}); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got hi=%h lo=%h exp 0/0", hi, lo); end
        @(negedge clk); rst = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        checks++; if (hi !== 32'hA5A5_5A5A || lo !== 32'hA5A5_5A5A) begin errors++; $display("FAIL pre_rst_write got hi=%h lo=%h exp a5a55a5a", hi, lo); end
        @(negedge clk); rst = 1'b1; start = 1'b1; wdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_priority got hi=%h lo=%h busy=%b exp 0/0/0", hi, lo, busy); end
        @(negedge clk); rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_dropped got busy=%b exp 0", busy); end
    endtask

    task automatic test_directed();
        logic [1:0]  d_op [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11};
        logic [31:0] d_x  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] d_y  [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] e_hi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd0};
        logic [31:0] e_lo [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        e_z  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] rh, rl;
        logic        rz;
        int          lat, dc;
        bit          pok;
        for (int i = 0; i < 5; i++) begin
            do_op(d_op[i], d_x[i], d_y[i], rh, rl, rz, lat, pok, dc);
            checks++; if (rh !== e_hi[i]) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, rh, e_hi[i]); end
            checks++; if (rl !== e_lo[i]) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, rl, e_lo[i]); end
            checks++; if (rz !== e_z[i]) begin errors++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, rz, e_z[i]); end
            checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, EXP_LAT); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, rh, rl;
        logic        rz;
        logic [64:0] e;
        int          lat, dc;
        bit          pok;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            e = ref_op(o, a, b);
            do_op(o, a, b, rh, rl, rz, lat, pok, dc);
            checks++; if (rh !== e[63:32]) begin errors++; $display("FAIL rnd%0d_hi op=%0d x=%h y=%h got=%h exp=%h", i, o, a, b, rh, e[63:32]); end
            checks++; if (rl !== e[31:0]) begin errors++; $display("FAIL rnd%0d_lo op=%0d x=%h y=%h got=%h exp=%h", i, o, a, b, rl, e[31:0]); end
            checks++; if (rz !== e[64]) begin errors++; $display("FAIL rnd%0d_dbz got=%b exp=%b", i, rz, e[64]); end
            checks++; if (lat != EXP_LAT || !pok) begin errors++; $display("FAIL rnd%0d_protocol latency=%0d exp=%0d busy/hold ok=%0d exp=1", i, lat, EXP_LAT, pok); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rh, rl;
        logic        rz;
        int          lat, dc1, dc2;
        bit          pok;
        do_op(2'b00, 32'd1000, 32'd3000, rh, rl, rz, lat, pok, dc1);
        checks++; if (rl !== 32'd3_000_000) begin errors++; $display("FAIL b2b_first_lo got=%h exp=%h", rl, 32'd3_000_000); end
        do_op(2'b10, 32'd1000, 32'd7, rh, rl, rz, lat, pok, dc2);
        checks++; if (rl !== 32'd142 || rh !== 32'd6) begin errors++; $display("FAIL b2b_second got hi=%0d lo=%0d exp 6/142", rh, rl); end
        checks++; if (dc2 - dc1 != ITER + 3) begin errors++; $display("FAIL b2b_throughput got=%0d exp=%0d", dc2 - dc1, ITER + 3); end
    endtask

    task automatic test_ignore_start();
        int          n_done = 0;
        logic [31:0] gl = 32'd0;
        logic [31:0] gh = 32'hDEAD_BEEF;
        @(negedge clk); op = 2'b00; x = 32'd3; y = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            start = (i == 10);
            if (i == 10) begin x = 32'd100; y = 32'd100; end
            @(posedge clk); #1;
            if (done === 1'b1) begin n_done++; gl = lo; gh = hi; end
        end
        start = 1'b0;
        checks++; if (n_done != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
        checks++; if (gl !== 32'd15 || gh !== 32'd0) begin errors++; $display("FAIL ignore_result got hi=%h lo=%h exp 0/f", gh, gl); end
    endtask

    task automatic test_abort();
        int          n_done = 0;
        logic [31:0] rh, rl;
        logic        rz;
        int          lat, dc;
        bit          pok;
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_5555;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b0; op = 2'b10; x = 32'd1000; y = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL abort_state got busy=%b done=%b hi=%h lo=%h exp 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        do_op(2'b00, 32'd2, 32'd3, rh, rl, rz, lat, pok, dc);
        checks++; if (rl !== 32'd6 || rh !== 32'd0 || lat != EXP_LAT) begin
            errors++; $display("FAIL abort_restart got hi=%h lo=%h lat=%0d exp 0/6/%0d", rh, rl, lat, EXP_LAT);
        end
    endtask

    task automatic test_regwrite();
        int n = 0;
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        checks++; if (hi !== 32'h1234 || lo !== 32'h1234) begin errors++; $display("FAIL wr_both got hi=%h lo=%h exp 1234", hi, lo); end
        @(negedge clk); wdata = 32'hDEAD; op = 2'b00; x = 32'd6; y = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wdata = 32'hBEEF;
        checks++; if (busy !== 1'b1 || hi !== 32'h1234 || lo !== 32'h1234) begin
            errors++; $display("FAIL wr_start_wins got busy=%b hi=%h lo=%h exp 1/1234/1234", busy, hi, lo);
        end
        repeat (5) @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'h1234 || lo !== 32'h1234) begin errors++; $display("FAIL wr_busy_dropped got hi=%h lo=%h exp 1234", hi, lo); end
        while (done !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
        checks++; if (done !== 1'b1 || lo !== 32'd42 || hi !== 32'd0) begin
            errors++; $display("FAIL wr_result got done=%b hi=%h lo=%h exp 1/0/2a", done, hi, lo);
        end
        @(posedge clk);
        @(negedge clk); hi_we = 1'b1; wdata = 32'h77;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checks++; if (hi !== 32'h77 || lo !== 32'd42) begin errors++; $display("FAIL wr_hi_only got hi=%h lo=%h exp 77/2a", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_regwrite();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: ITER, default 32, number of shift/add-sub iterations per operation.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
REQ-006 x  input  32  multiplicand/dividend; sampled with start.
REQ-007 y  input  32  multiplier/divisor; sampled with start.
REQ-008 hi_we  input  1  write hi from wdata; honoured only in IDLE.
REQ-009 lo_we  input  1  write lo from wdata; honoured only in IDLE.
REQ-010 wdata  input  32  write data for hi_we/lo_we.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when hi/lo hold the new result.
REQ-013 div_by_zero  output  1  pulses with done when a divide had y==0.
REQ-014 hi  output  32  HI register: product[63:32] or remainder.
REQ-015 lo  output  32  LO register: product[31:0] or quotient.

Function
REQ-016 States SHALL be IDLE, CALC, FIX, DONE: IDLE->CALC on start, CALC->FIX after ITER cycles, FIX->DONE unconditionally, DONE->IDLE unconditionally.
REQ-017 Start sampled at edge N SHALL produce done=1 during cycle N+ITER+2 (34 cycles for ITER=32), with hi/lo updated at that same edge.
REQ-018 busy SHALL be 1 from cycle N+1 through the done cycle inclusive; start while busy SHALL be ignored, not queued.
REQ-019 Operands SHALL be captured at start; input changes during busy SHALL NOT affect the result.
REQ-020 MULT/DIV SHALL operate on magnitudes in CALC and apply sign correction in FIX; MULTU/DIVU SHALL pass through FIX unchanged.
REQ-021 MULT/MULTU SHALL yield the exact 64-bit two's-complement/unsigned product in {hi,lo}.
REQ-022 DIV SHALL truncate the quotient toward zero, with the remainder taking the dividend's sign.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no flag.
REQ-024 Divide with y==0 SHALL keep full latency and give lo=0xFFFFFFFF and hi=x, with div_by_zero=1 in the done cycle.
REQ-025 hi/lo SHALL hold their previous values while busy; intermediate values SHALL NOT be visible.
REQ-026 hi_we/lo_we in IDLE SHALL update the register at the next edge; both may be written in the same cycle.
REQ-027 If start and hi_we/lo_we are high in the same IDLE cycle, start SHALL win and the writes SHALL be dropped.
REQ-028 hi_we/lo_we while busy SHALL be dropped.
REQ-029 A start in the cycle after done, with state back in IDLE, SHALL be accepted (back-to-back throughput = ITER+3 cycles).

Reset
REQ-030 rst SHALL force IDLE and set hi=0, lo=0, busy=0, done=0, div_by_zero=0 at the next edge.
REQ-031 rst during CALC/FIX/DONE SHALL abort the operation with no done pulse, and the next start SHALL behave as from power-up.
REQ-032 rst SHALL take priority over start, hi_we and lo_we in the same cycle.

Structure
REQ-033 Shared package muldiv_pkg SHALL hold the op encoding, the state encoding and the ITER default.
REQ-034 One combinational sub-module muldiv_step SHALL perform a single iteration (conditional add + shift for multiply, trial subtract + shift for divide), instantiated once.
REQ-035 The iteration counter SHALL be $clog2(ITER)+1 bits wide, and no multi-cycle or combinational 32x32 multiplier SHALL be used.

Verification
REQ-036 MULTU x=0xFFFFFFFF y=0xFFFFFFFF -> done at start+34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT x=0xFFFFFFFD(-3) y=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21).
REQ-038 DIV x=-7 y=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU x=100 y=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1.
REQ-039 Start MULTU 3*5, assert start again at cycle +10 with changed x/y -> single done with lo=15, second start ignored.
REQ-040 Start DIVU, pulse rst at cycle +20 -> no done, hi=lo=0, busy=0; new MULTU 2*3 -> lo=6 after 34 cycles.
REQ-041 IDLE: hi_we+lo_we wdata=0x1234 -> hi=lo=0x1234; then start with hi_we in same cycle -> hi unchanged until the result lands.
